// File: rtl/soma_array_pkg.sv
// Shared types and helpers for the soma_array neuron bank.
package soma_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Saturating signed add, clamped to the range of a w-bit two's complement value (w <= 31).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi[31:0];
        end else if (sum < lo) begin
            return lo[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/soma_array_if.sv
// Event-in / spike-out handshake bundle for soma_array.
interface soma_array_if #(
    parameter int ID_W = 4,
    parameter int W_W  = 8,
    parameter int T_W  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ID_W-1:0]       in_id;
    logic signed [W_W-1:0] in_weight;
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_W-1:0]       out_id;
    logic [T_W-1:0]        out_time;

    // Producer of synaptic events and consumer of spikes.
    modport master (
        output in_valid, in_id, in_weight, out_ready,
        input  in_ready, out_valid, out_id, out_time
    );

    // The neuron bank itself.
    modport slave (
        input  in_valid, in_id, in_weight, out_ready,
        output in_ready, out_valid, out_id, out_time
    );
endinterface

// File: rtl/soma_array_fifo.sv
// Synchronous spike FIFO; a push on a full FIFO is accepted when a pop happens in the same cycle.
module soma_array_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Storage write; contents need no reset since empty_o gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/soma_array.sv
// Time-multiplexed bank of leaky integrate-and-fire somas with a spike output FIFO.
module soma_array
    import soma_array_pkg::*;
#(
    parameter int N_NEURON = 16,
    parameter int V_W      = 16,
    parameter int W_W      = 8,
    parameter int REFR_W   = 8,
    parameter int T_W      = 16,
    parameter int LEAK_SH  = 4,
    parameter int FIFO_D   = 8,
    localparam int ID_W    = $clog2(N_NEURON)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [V_W-1:0] cfg_v_rest,
    input  logic signed [V_W-1:0] cfg_v_th,
    input  logic [REFR_W-1:0]     cfg_refr,
    input  logic [T_W-1:0]        cfg_delay,
    soma_array_if.slave           bus,
    input  logic                  tick,
    input  logic                  en_we,
    input  logic [ID_W-1:0]       en_id,
    input  logic                  en_val,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  overrun
);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_NEURON - 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [T_W-1:0]  tstamp;
    } spike_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       idx_q;
    logic [T_W-1:0]        tick_cnt_q;
    logic                  overrun_q;
    logic                  first_q;
    logic signed [V_W-1:0] v_rest_s_q;
    logic signed [V_W-1:0] v_th_s_q;
    logic [REFR_W-1:0]     refr_s_q;
    logic [T_W-1:0]        delay_s_q;

    logic signed [V_W-1:0] v_q    [N_NEURON];
    logic [REFR_W-1:0]     refr_q [N_NEURON];
    logic [N_NEURON-1:0]   en_q;

    logic                  sweep_start;
    logic                  first_tick;
    logic                  ev_ok;
    logic signed [V_W-1:0] ev_base;
    logic signed [31:0]    ev_sum;
    logic signed [V_W-1:0] ev_v;

    logic signed [V_W-1:0] cur_v;
    logic [REFR_W-1:0]     cur_refr;
    logic                  cur_en;
    logic signed [V_W:0]   lk_diff;
    logic signed [V_W:0]   lk_d;
    logic signed [V_W:0]   lk_new;
    logic                  fire_due;
    logic                  step_stall;
    logic                  step_adv;
    logic                  step_wr;
    logic                  push;
    logic signed [V_W-1:0] step_v;
    logic [REFR_W-1:0]     step_refr;

    spike_t                push_spk;
    spike_t                head_spk;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    assign sweep_start   = (state_q == IDLE) && tick;
    assign first_tick    = sweep_start && first_q;
    assign busy          = (state_q != IDLE);
    assign sweep_done    = (state_q == DONE);
    assign overrun       = overrun_q;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = !fifo_empty;
    assign bus.out_id    = head_spk.id;
    assign bus.out_time  = head_spk.tstamp;
    assign pop           = bus.out_valid && bus.out_ready;

    // Integrate path: event lands on the retained V, or on v_rest when the first tick reloads the bank.
    always_comb begin
        ev_ok   = bus.in_valid && (state_q == IDLE) && en_q[bus.in_id] && (refr_q[bus.in_id] == '0);
        ev_base = first_tick ? cfg_v_rest : v_q[bus.in_id];
        ev_sum  = sat_add(32'(ev_base), 32'(bus.in_weight), V_W);
        ev_v    = ev_sum[V_W-1:0];
    end

    // Sweep step for the current index: refractory, fire (stalls on a full FIFO), or leak.
    always_comb begin
        cur_v      = v_q[idx_q];
        cur_refr   = refr_q[idx_q];
        cur_en     = en_q[idx_q];
        lk_diff    = {cur_v[V_W-1], cur_v} - {v_rest_s_q[V_W-1], v_rest_s_q};
        lk_d       = lk_diff >>> LEAK_SH;
        lk_new     = {cur_v[V_W-1], cur_v} - lk_d;
        fire_due   = 1'b0;
        step_stall = 1'b0;
        step_adv   = 1'b0;
        step_v     = lk_new[V_W-1:0];
        step_refr  = cur_refr;
        if (state_q == SWEEP) begin
            fire_due   = cur_en && (cur_refr == '0) && (cur_v >= v_th_s_q);
            step_stall = fire_due && fifo_full && !pop;
            step_adv   = !step_stall;
        end
        if (cur_refr != '0) begin
            step_v    = v_rest_s_q;
            step_refr = cur_refr - 1'b1;
        end else if (cur_v >= v_th_s_q) begin
            step_v    = v_rest_s_q;
            step_refr = refr_s_q;
        end
        step_wr         = step_adv && cur_en;
        push            = fire_due && !step_stall;
        push_spk.id     = idx_q;
        push_spk.tstamp = tick_cnt_q + delay_s_q;
    end

    // Next-state logic for the IDLE/SWEEP/DONE controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = SWEEP;
            SWEEP:   if (step_adv && (idx_q == LAST_IDX)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Sweep index, timestep count, sticky overrun and per-sweep configuration snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            tick_cnt_q <= '0;
            overrun_q  <= 1'b0;
            first_q    <= 1'b1;
            v_rest_s_q <= '0;
            v_th_s_q   <= '0;
            refr_s_q   <= '0;
            delay_s_q  <= '0;
        end else begin
            if (sweep_start) begin
                idx_q      <= '0;
                first_q    <= 1'b0;
                v_rest_s_q <= cfg_v_rest;
                v_th_s_q   <= cfg_v_th;
                refr_s_q   <= cfg_refr;
                delay_s_q  <= cfg_delay;
            end else if (step_adv) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == DONE) tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
        end
    end

    // Neuron state arrays: first-tick reload, event integration, sweep writeback, enable writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURON; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
            end
            en_q <= '1;
        end else begin
            if (first_tick) begin
                for (int i = 0; i < N_NEURON; i++) v_q[i] <= cfg_v_rest;
            end
            if (ev_ok) v_q[bus.in_id] <= ev_v;
            if (step_wr) begin
                v_q[idx_q]    <= step_v;
                refr_q[idx_q] <= step_refr;
            end
            if (en_we) en_q[en_id] <= en_val;
        end
    end

    soma_array_fifo #(
        .WIDTH ($bits(spike_t)),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_spk),
        .pop_i   (pop),
        .data_o  (head_spk),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_soma_array.sv
// Directed bench for soma_array: integrate, fire, refractory, saturation, leak, FIFO stall, overrun, kill, reset.
module tb_soma_array;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] cfg_v_rest = 16'sd0;
    logic signed [15:0] cfg_v_th   = 16'sd100;
    logic [7:0]         cfg_refr   = 8'd2;
    logic [15:0]        cfg_delay  = 16'd5;
    logic               tick   = 1'b0;
    logic               en_we  = 1'b0;
    logic [3:0]         en_id  = 4'd0;
    logic               en_val = 1'b1;
    logic               busy, sweep_done, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] t;
    } spk_t;
    spk_t spike_q[$];

    soma_array_if #(.ID_W(4), .W_W(8), .T_W(16)) bus ();

    soma_array dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_v_rest (cfg_v_rest),
        .cfg_v_th   (cfg_v_th),
        .cfg_refr   (cfg_refr),
        .cfg_delay  (cfg_delay),
        .bus        (bus),
        .tick       (tick),
        .en_we      (en_we),
        .en_id      (en_id),
        .en_val     (en_val),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            spike_q.push_back(spk_t'({bus.out_id, bus.out_time}));
    end

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", tag, busy, k);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic do_tick(input string tag);
        pulse_tick();
        wait_idle(tag);
    endtask

    task automatic send_event(input logic [3:0] id, input logic signed [7:0] w);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_id = id; bus.in_weight = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic set_enable(input logic [3:0] id, input logic val);
        @(negedge clk); en_we = 1'b1; en_id = id; en_val = val;
        @(negedge clk); en_we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; tick = 1'b0; en_we = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_clean(input logic signed [15:0] vr);
        apply_reset();
        cfg_v_rest = vr;
        do_tick("init");
        spike_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (sweep_done !== 1'b0) begin n_bad++; $display("FAIL rst_sweep_done: got %b want 0", sweep_done); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        rst = 1'b1;
        cfg_v_rest = -16'sd50;
        do_tick("reload");
        n_cmp += 3;
        if (dut.v_q[0] !== -16'sd50) begin n_bad++; $display("FAIL reload_v0: got %0d want -50", dut.v_q[0]); end
        if (dut.v_q[9] !== -16'sd50) begin n_bad++; $display("FAIL reload_v9: got %0d want -50", dut.v_q[9]); end
        if (dut.tick_cnt_q !== 16'd1) begin n_bad++; $display("FAIL reload_tick_cnt: got %0d want 1", dut.tick_cnt_q); end
        cfg_v_rest = 16'sd0;
    endtask

    task automatic test_latency();
        int cyc;
        start_clean(16'sd0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        cyc = 1;
        while (sweep_done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 17) begin n_bad++; $display("FAIL latency: got %0d cycles want 17", cyc); end
        @(negedge clk);
        n_cmp += 2;
        if (sweep_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", sweep_done); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL latency_busy: got %b want 0", busy); end
    endtask

    task automatic test_fire_refractory();
        start_clean(16'sd0);
        send_event(4'd3, 8'sd60);
        send_event(4'd3, 8'sd50);
        do_tick("fire");
        n_cmp++;
        if (spike_q.size() !== 1) begin
            n_bad++; $display("FAIL fire_count: got %0d want 1", spike_q.size());
        end else begin
            n_cmp += 2;
            if (spike_q[0].id !== 4'd3) begin n_bad++; $display("FAIL fire_id: got %0d want 3", spike_q[0].id); end
            if (spike_q[0].t !== 16'd6) begin n_bad++; $display("FAIL fire_time: got %0d want 6", spike_q[0].t); end
        end
        n_cmp += 2;
        if (dut.v_q[3] !== 16'sd0) begin n_bad++; $display("FAIL fire_v3: got %0d want 0", dut.v_q[3]); end
        if (dut.refr_q[3] !== 8'd2) begin n_bad++; $display("FAIL fire_refr3: got %0d want 2", dut.refr_q[3]); end
        spike_q.delete();
        send_event(4'd3, 8'sd127);
        n_cmp++;
        if (dut.v_q[3] !== 16'sd0) begin n_bad++; $display("FAIL refr_drop1: got %0d want 0", dut.v_q[3]); end
        do_tick("refr1");
        send_event(4'd3, 8'sd127);
        n_cmp++;
        if (dut.v_q[3] !== 16'sd0) begin n_bad++; $display("FAIL refr_drop2: got %0d want 0", dut.v_q[3]); end
        do_tick("refr2");
        send_event(4'd3, 8'sd127);
        n_cmp++;
        if (dut.v_q[3] !== 16'sd127) begin n_bad++; $display("FAIL refr_accept: got %0d want 127", dut.v_q[3]); end
        do_tick("refire");
        n_cmp++;
        if (spike_q.size() !== 1) begin
            n_bad++; $display("FAIL refire_count: got %0d want 1", spike_q.size());
        end else begin
            n_cmp++;
            if (spike_q[0] !== spk_t'({4'd3, 16'd9})) begin
                n_bad++; $display("FAIL refire_spike: got id=%0d t=%0d want id=3 t=9", spike_q[0].id, spike_q[0].t);
            end
        end
    endtask

    task automatic test_saturation();
        start_clean(16'sd0);
        for (int i = 0; i < 257; i++) send_event(4'd1, 8'sd127);
        send_event(4'd1, 8'sd121);
        n_cmp++;
        if (dut.v_q[1] !== 16'sd32760) begin n_bad++; $display("FAIL sat_pre: got %0d want 32760", dut.v_q[1]); end
        send_event(4'd1, 8'sd100);
        n_cmp++;
        if (dut.v_q[1] !== 16'sd32767) begin n_bad++; $display("FAIL sat_hi: got %0d want 32767", dut.v_q[1]); end
        send_event(4'd1, 8'sd127);
        n_cmp++;
        if (dut.v_q[1] !== 16'sd32767) begin n_bad++; $display("FAIL sat_hi_hold: got %0d want 32767", dut.v_q[1]); end
        for (int i = 0; i < 256; i++) send_event(4'd2, 8'sh80);
        n_cmp++;
        if (dut.v_q[2] !== 16'sh8000) begin n_bad++; $display("FAIL sat_lo_pre: got %0d want -32768", dut.v_q[2]); end
        send_event(4'd2, 8'sh80);
        n_cmp++;
        if (dut.v_q[2] !== 16'sh8000) begin n_bad++; $display("FAIL sat_lo_hold: got %0d want -32768", dut.v_q[2]); end
    endtask

    task automatic test_leak();
        start_clean(16'sd0);
        send_event(4'd5, 8'sd64);
        do_tick("leak0");
        n_cmp++;
        if (dut.v_q[5] !== 16'sd60) begin n_bad++; $display("FAIL leak_rest0: got %0d want 60", dut.v_q[5]); end
        start_clean(16'sd0);
        send_event(4'd5, 8'sd64);
        cfg_v_rest = -16'sd16;
        do_tick("leak16");
        n_cmp += 2;
        if (dut.v_q[5] !== 16'sd59) begin n_bad++; $display("FAIL leak_rest_m16: got %0d want 59", dut.v_q[5]); end
        if (dut.v_q[0] !== -16'sd1) begin n_bad++; $display("FAIL leak_up: got %0d want -1", dut.v_q[0]); end
        cfg_v_rest = 16'sd0;
    endtask

    task automatic test_back_to_back();
        start_clean(16'sd0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_id = 4'd4; bus.in_weight = 8'sd100; tick = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; tick = 1'b0;
        wait_idle("b2b");
        n_cmp++;
        if (spike_q.size() !== 1) begin
            n_bad++; $display("FAIL b2b_count: got %0d want 1", spike_q.size());
        end else begin
            n_cmp++;
            if (spike_q[0] !== spk_t'({4'd4, 16'd6})) begin
                n_bad++; $display("FAIL b2b_spike: got id=%0d t=%0d want id=4 t=6", spike_q[0].id, spike_q[0].t);
            end
        end
    endtask

    task automatic test_fifo_stall();
        int k;
        start_clean(16'sd0);
        for (int i = 0; i < 16; i++) send_event(4'(i), 8'sd100);
        @(negedge clk); bus.out_ready = 1'b0;
        pulse_tick();
        repeat (30) @(negedge clk);
        n_cmp += 3;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", busy); end
        if (dut.idx_q !== 4'd8) begin n_bad++; $display("FAIL stall_idx: got %0d want 8", dut.idx_q); end
        if (spike_q.size() !== 0) begin n_bad++; $display("FAIL stall_popped: got %0d want 0", spike_q.size()); end
        bus.out_ready = 1'b1;
        wait_idle("stall");
        k = 0;
        while (bus.out_valid === 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (spike_q.size() !== 16) begin
            n_bad++; $display("FAIL stall_count: got %0d want 16", spike_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (spike_q[i] !== spk_t'({4'(i), 16'd6})) begin
                    n_bad++;
                    $display("FAIL stall_spike%0d: got id=%0d t=%0d want id=%0d t=6", i, spike_q[i].id, spike_q[i].t, i);
                end
            end
        end
    endtask

    task automatic test_overrun();
        start_clean(16'sd0);
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        pulse_tick();
        repeat (3) @(negedge clk);
        pulse_tick();
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        wait_idle("ovr");
        n_cmp++;
        if (dut.tick_cnt_q !== 16'd2) begin n_bad++; $display("FAIL ovr_tick_cnt: got %0d want 2", dut.tick_cnt_q); end
        do_tick("ovr2");
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_kill();
        start_clean(16'sd0);
        set_enable(4'd7, 1'b0);
        send_event(4'd7, 8'sd127);
        send_event(4'd6, 8'sd120);
        n_cmp += 2;
        if (dut.v_q[7] !== 16'sd0) begin n_bad++; $display("FAIL kill_v7: got %0d want 0", dut.v_q[7]); end
        if (dut.v_q[6] !== 16'sd120) begin n_bad++; $display("FAIL kill_v6: got %0d want 120", dut.v_q[6]); end
        do_tick("kill");
        n_cmp++;
        if (spike_q.size() !== 1) begin
            n_bad++; $display("FAIL kill_count: got %0d want 1", spike_q.size());
        end else begin
            n_cmp++;
            if (spike_q[0].id !== 4'd6) begin n_bad++; $display("FAIL kill_id: got %0d want 6", spike_q[0].id); end
        end
        set_enable(4'd7, 1'b1);
        send_event(4'd7, 8'sd127);
        n_cmp++;
        if (dut.v_q[7] !== 16'sd127) begin n_bad++; $display("FAIL revive_v7: got %0d want 127", dut.v_q[7]); end
    endtask

    task automatic test_reset_mid_sweep();
        start_clean(16'sd0);
        send_event(4'd0, 8'sd100);
        @(negedge clk); bus.out_ready = 1'b0;
        pulse_tick();
        repeat (4) @(negedge clk);
        pulse_tick();
        n_cmp += 3;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
        if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid_pre: got %b want 1", bus.out_valid); end
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL mid_ovr_pre: got %b want 1", overrun); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 5;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        if (sweep_done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", sweep_done); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL mid_overrun: got %b want 0", overrun); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_id     = 4'd0;
        bus.in_weight = 8'sd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_latency();
        test_fire_refractory();
        test_saturation();
        test_leak();
        test_back_to_back();
        test_fifo_stall();
        test_overrun();
        test_kill();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
